// File: rtl/rom_reader_pkg.sv
// Shared types and widths for the program-ROM burst reader.
package rom_reader_pkg;

    localparam int unsigned ROM_ADDR_W = 14;
    localparam int unsigned ROM_DATA_W = 8;
    localparam int unsigned LEN_W      = 15;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StHold,
        StDone
    } state_e;

endpackage

// File: rtl/rom_burst_reader.sv
// Burst reader for a 16Kx8 registered-output ROM: one access per byte, valid/ready
// hand-off and a running 8-bit checksum of the bytes accepted by the consumer.
module rom_burst_reader
    import rom_reader_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  phi0,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROM_ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ROM_ADDR_W-1:0] A,
    output logic                  CS_b,
    output logic                  OE_b,
    input  logic [ROM_DATA_W-1:0] Din,
    output logic [ROM_DATA_W-1:0] byte_data,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [ROM_DATA_W-1:0] checksum
);

    localparam int unsigned WaitW = $clog2(WAIT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    logic [ROM_ADDR_W-1:0] addr_q, addr_d;
    logic [ROM_ADDR_W-1:0] a_q, a_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [ROM_DATA_W-1:0] csum_q, csum_d;
    logic [ROM_DATA_W-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  rom_en_b_q, rom_en_b_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        a_d        = a_q;
        rem_d      = rem_q;
        csum_d     = csum_q;
        data_d     = data_q;
        valid_d    = valid_q;
        rom_en_b_d = rom_en_b_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    csum_d = '0;
                    if (length != '0) begin
                        addr_d     = start_addr;
                        a_d        = start_addr;
                        rem_d      = length;
                        wait_d     = '0;
                        rom_en_b_d = 1'b0;
                        state_d    = StAddr;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StAddr: begin
                if (abort) begin
                    rom_en_b_d = 1'b1;
                    state_d    = StIdle;
                end else if (wait_q == WaitLast) begin
                    data_d     = Din;
                    valid_d    = 1'b1;
                    addr_d     = addr_q + ROM_ADDR_W'(1);
                    rom_en_b_d = 1'b1;
                    state_d    = StHold;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StHold: begin
                // Abort beats a same-edge handshake: the pending byte is dropped uncounted.
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (byte_ready) begin
                    valid_d = 1'b0;
                    csum_d  = csum_q + data_q;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        a_d        = addr_q;
                        wait_d     = '0;
                        rom_en_b_d = 1'b0;
                        state_d    = StAddr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d    = StIdle;
                valid_d    = 1'b0;
                rom_en_b_d = 1'b1;
            end
        endcase

        busy_d = (state_d == StAddr) || (state_d == StHold);
    end

    always_ff @(posedge phi0 or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            addr_q     <= '0;
            a_q        <= '0;
            rem_q      <= '0;
            csum_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            rom_en_b_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            a_q        <= a_d;
            rem_q      <= rem_d;
            csum_q     <= csum_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            rom_en_b_q <= rom_en_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign A          = a_q;
    assign CS_b       = rom_en_b_q;
    assign OE_b       = rom_en_b_q;
    assign byte_data  = data_q;
    assign byte_valid = valid_q;
    assign checksum   = csum_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader against a registered-output ROM model.
module tb_rom_burst_reader;

    logic        phi0 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] start_addr = '0;
    logic [14:0] length = '0;
    logic        abort = 1'b0;
    logic        busy, done, CS_b, OE_b, byte_valid;
    logic [13:0] A;
    logic [7:0]  byte_data, checksum;
    logic        byte_ready = 1'b1;
    logic [7:0]  rom_dout = 8'hEE;
    logic [7:0]  rom [0:16383];

    int checks = 0;
    int errors = 0;
    int cs_cycles = 0;
    int done_cnt = 0;

    typedef struct {
        logic [13:0] addr;
        logic [14:0] len;
        logic        poke;
        logic [7:0]  first_byte;
        logic [7:0]  last_byte;
        logic [7:0]  csum;
        logic [13:0] last_a;
    } vec_t;

    vec_t vecs [5];

    rom_burst_reader #(.WAIT_CYCLES(1)) dut (
        .phi0       (phi0),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .A          (A),
        .CS_b       (CS_b),
        .OE_b       (OE_b),
        .Din        (rom_dout),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .checksum   (checksum)
    );

    always #5 phi0 = ~phi0;

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 8'(i) ^ 8'h5A;
    end

    always @(posedge phi0) begin
        rom_dout <= (!CS_b && !OE_b) ? rom[A] : 8'hEE;
        if (!CS_b) cs_cycles <= cs_cycles + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input string name, input int limit);
        int k = 0;
        while (!byte_valid && k < limit) begin
            @(negedge phi0);
            k++;
        end
        check(name, byte_valid, 1);
    endtask

    task automatic run_burst(input vec_t v);
        int n = 0;
        int got = 0;
        int acc0;
        logic [7:0]  first_b = '0;
        logic [7:0]  last_b = '0;
        logic [13:0] ea;
        acc0 = cs_cycles;
        @(negedge phi0);
        start = 1'b1; start_addr = v.addr; length = v.len; byte_ready = 1'b1;
        @(negedge phi0);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!done && n < 3 * int'(v.len) + 20) begin
            if (v.poke && (n == 1 || n == 2)) begin
                start = 1'b1; start_addr = 14'h2000; length = 15'd7;
            end else begin
                start = 1'b0;
            end
            if (byte_valid) begin
                ea = v.addr + 14'(got);
                check("byte_data", byte_data, rom[ea]);
                check("byte_addr", A, ea);
                check("byte_time", n, 3 * got + 2);
                if (got == 0) first_b = byte_data;
                last_b = byte_data;
                got++;
            end
            @(negedge phi0);
            n++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("done_edge", n, 3 * int'(v.len));
        check("busy_in_done", busy, 0);
        check("byte_count", got, v.len);
        check("first_byte", first_b, v.first_byte);
        check("last_byte", last_b, v.last_byte);
        check("checksum", checksum, v.csum);
        check("last_A", A, v.last_a);
        check("rom_accesses", cs_cycles - acc0, 2 * int'(v.len));
        @(negedge phi0);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int acc0;
        int dc0;
        vecs[0] = '{addr: 14'h0010, len: 15'd4, poke: 1'b0, first_byte: 8'h4A,
                    last_byte: 8'h49, csum: 8'h26, last_a: 14'h0013};
        vecs[1] = '{addr: 14'h3FFE, len: 15'd3, poke: 1'b0, first_byte: 8'hA4,
                    last_byte: 8'h5A, csum: 8'hA3, last_a: 14'h0000};
        vecs[2] = '{addr: 14'h0100, len: 15'd1, poke: 1'b0, first_byte: 8'h5A,
                    last_byte: 8'h5A, csum: 8'h5A, last_a: 14'h0100};
        vecs[3] = '{addr: 14'h00A5, len: 15'd2, poke: 1'b1, first_byte: 8'hFF,
                    last_byte: 8'hFC, csum: 8'hFB, last_a: 14'h00A6};
        vecs[4] = '{addr: 14'h1234, len: 15'd5, poke: 1'b0, first_byte: 8'h6E,
                    last_byte: 8'h62, csum: 8'h18, last_a: 14'h1238};

        #12;
        check("rst_A", A, 0);
        check("rst_CS_b", CS_b, 1);
        check("rst_OE_b", OE_b, 1);
        check("rst_byte_data", byte_data, 0);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        @(negedge phi0);
        reset = 1'b0;
        @(negedge phi0);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        // Backpressure on the second byte, then abort while the third byte is held.
        byte_ready = 1'b0;
        dc0 = done_cnt;
        @(negedge phi0);
        start = 1'b1; start_addr = 14'h0010; length = 15'd4;
        @(negedge phi0);
        start = 1'b0;
        wait_valid("bp_first_valid", 20);
        check("bp_first_data", byte_data, 8'h4A);
        byte_ready = 1'b1;
        @(negedge phi0);
        byte_ready = 1'b0;
        wait_valid("bp_second_valid", 20);
        check("bp_second_data", byte_data, 8'h4B);
        acc0 = cs_cycles;
        for (int k = 0; k < 5; k++) begin
            @(negedge phi0);
            check("bp_valid_hold", byte_valid, 1);
            check("bp_data_hold", byte_data, 8'h4B);
            check("bp_cs_high", CS_b, 1);
            check("bp_oe_high", OE_b, 1);
            check("bp_A_hold", A, 14'h0011);
            check("bp_busy", busy, 1);
        end
        check("bp_no_access", cs_cycles - acc0, 0);
        byte_ready = 1'b1;
        @(negedge phi0);
        byte_ready = 1'b0;
        wait_valid("ab_third_valid", 20);
        check("ab_third_data", byte_data, 8'h48);
        check("ab_csum_before", checksum, 8'h95);
        abort = 1'b1;
        byte_ready = 1'b1;
        @(negedge phi0);
        abort = 1'b0;
        byte_ready = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_valid", byte_valid, 0);
        check("ab_cs", CS_b, 1);
        check("ab_oe", OE_b, 1);
        repeat (8) @(negedge phi0);
        check("ab_no_done", done_cnt - dc0, 0);
        check("ab_checksum", checksum, 8'h95);
        check("ab_idle", busy, 0);
        byte_ready = 1'b1;

        // Zero-length burst.
        acc0 = cs_cycles;
        @(negedge phi0);
        start = 1'b1; start_addr = 14'h0555; length = 15'd0;
        @(negedge phi0);
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_checksum", checksum, 0);
        @(negedge phi0);
        check("len0_done_drop", done, 0);
        check("len0_no_access", cs_cycles - acc0, 0);

        // Asynchronous reset between edges while a ROM access is in flight.
        @(negedge phi0);
        start = 1'b1; start_addr = 14'h0200; length = 15'd3;
        @(negedge phi0);
        start = 1'b0;
        check("ra_cs_low", CS_b, 0);
        #2 reset = 1'b1;
        #1;
        check("ra_cs", CS_b, 1);
        check("ra_oe", OE_b, 1);
        check("ra_valid", byte_valid, 0);
        check("ra_busy", busy, 0);
        check("ra_A", A, 0);
        @(negedge phi0);
        reset = 1'b0;
        run_burst(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Bus initiator for the 16K×8 program ROM (23128-style: 14-bit address, active-low CS_b/OE_b, registered data out). It accepts a start address and byte count and issues one ROM read per byte. Captured bytes stream out on a valid/ready interface, and the block keeps a running 8-bit checksum. It sits between the ROM and consumers such as the boot-time shadow-RAM copier and the ROM self-test.

## Interface
Parameters:
- WAIT_CYCLES, 1, extra cycles address/CS_b/OE_b are held before Din is sampled (minimum 1; ROM registers data on the edge after the address is applied)

Ports:
- phi0  in  1  system clock, all state on rising edge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  begin burst; honoured only when busy=0
- start_addr  in  14  first ROM address
- length  in  15  bytes to read, 0..16384
- abort  in  1  terminate burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse: burst completed normally
- A  out  14  ROM address
- CS_b  out  1  ROM chip select, active-low
- OE_b  out  1  ROM output enable, active-low
- Din  in  8  ROM data (ROM Dout)
- byte_data  out  8  captured byte
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  consumer accepts byte
- checksum  out  8  sum mod 256 of bytes handed off in current/last burst

## Operation
- States: IDLE, ADDR, HOLD, DONE.
- IDLE: CS_b=OE_b=1, byte_valid=0. On start:
  - length≠0: load addr←start_addr, remaining←length, checksum←0, go to ADDR.
  - length=0: checksum←0, go to DONE.
- ADDR: A=addr, CS_b=OE_b=0 for WAIT_CYCLES+1 cycles (wait counter). On the edge ending the last cycle: byte_data←Din, byte_valid←1, addr←addr+1 mod 16384, go to HOLD.
- HOLD: CS_b=OE_b=1, A holds last driven value, byte_data/byte_valid stable.
  - On valid&ready: checksum←checksum+byte_data (8-bit wrap), remaining−1.
  - If remaining becomes 0, go to DONE; otherwise go to ADDR.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- busy=1 in ADDR and HOLD only. start while busy is ignored.
- abort in ADDR or HOLD: at the next edge go to IDLE, CS_b=OE_b=1, byte_valid=0, no done pulse, checksum retains the sum of accepted bytes. abort in IDLE/DONE has no effect.
- abort and a handshake on the same edge: the abort wins. The byte is not counted.
- Address wraps 0x3FFF→0x0000. length=16384 reads the whole ROM once.

## Timing
- Reset values: A=0, CS_b=1, OE_b=1, byte_data=0, byte_valid=0, busy=0, done=0, checksum=0, state IDLE. All take effect immediately on reset assertion.
- Start accepted at edge E0: A/CS_b/OE_b are driven from E0.
- Din is sampled at edge E0+WAIT_CYCLES+1, and byte_valid rises after that edge.
- With WAIT_CYCLES=1 and byte_ready held high, one byte is delivered per 3 cycles.
- done asserts in the cycle after the final handshake edge.
- Backpressure only stretches HOLD. No ROM access occurs while a byte is pending.

## Structure
- Package rom_reader_pkg holds: state enum (IDLE, ADDR, HOLD, DONE), ROM_ADDR_W=14, ROM_DATA_W=8, LEN_W=15.
- Single module. Wait counter, remaining counter and checksum are inline; no sub-module.

## Test plan
- ROM preload ram[i]=i[7:0]^8'h5A; start_addr=0x0010, length=4, byte_ready=1:
  - bytes 4A,4B,48,49 are valid after E2, E5, E8, E11;
  - done is high in the cycle after E12;
  - checksum=0x26.
- start_addr=0x3FFE, length=3 -> A sequence 3FFE, 3FFF, 0000; bytes match the preload.
- byte_ready low for 5 cycles on the second byte -> byte_data/byte_valid stable, CS_b=OE_b=1, A unchanged, no extra ROM access.
- abort asserted in HOLD of the third byte (ready low) -> next cycle busy=0, byte_valid=0, CS_b=1, done never pulses, checksum = sum of the first two bytes.
- length=0 -> done pulses the cycle after start with CS_b never low and checksum=0. A start pulse during an active burst changes nothing.
- reset asserted between edges mid-ADDR -> CS_b/OE_b go to 1, byte_valid to 0 and busy to 0 before the next phi0 edge. After release, a new burst runs correctly.
